muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It is started from the EXE stage when the decoded ALU operation is MULT, MULTU, DIV or DIVU. It takes 32 shift/add or shift/subtract iterations plus one sign-fix cycle to compute the result, then commits HI/LO. While it is busy, it produces the stall request that the control unit folds into `write_pc_ir`, so that MFHI/MFLO and back-to-back mul/div wait for the result.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk` input 1: the only clock; everything is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: EXE stage holds a mul/div instruction.
- `op` input 2: operation; 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `a` input WIDTH: rs operand, after forwarding.
- `b` input WIDTH: rt operand, after forwarding.
- `rd_hilo` input 1: EXE/ID holds MFHI/MFLO.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.
- `busy` output 1: an operation is in flight.
- `done` output 1: one-cycle pulse; HI/LO were updated on this edge.
- `stall` output 1: combinational; pipeline must hold PC/IR.

## Operation
- **States:**
  - IDLE
  - CALC: 5-bit iteration counter.
  - FIX: sign correction.
- **IDLE:**
  - `start`=1 latches `op`, |a|, |b| (magnitudes for MULT/DIV, raw values for MULTU/DIVU) and the sign flags.
  - Clears the 64-bit accumulator and the counter.
  - Moves to CALC.
- **CALC, multiply:**
  - Each cycle, if multiplier bit0=1, add the multiplicand to the accumulator upper half.
  - Then shift {carry, acc} right 1.
- **CALC, divide:**
  - Restoring algorithm.
  - Each cycle, shift the {rem, quot} pair left 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quot bit0.
- **CALC exit:** after the counter reaches WIDTH-1, go to FIX.
- **FIX, write-back:**
  - Signed multiply: negate the 64-bit product if sign_a^sign_b.
  - Signed divide: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
  - HI ← product[63:32] or remainder; LO ← product[31:0] or quotient.
  - `done`=1; return to IDLE.
- **Divide by zero:** LO = all ones, HI = `a` as given, for both DIV and DIVU. The full cycle count still applies.
- **Signed overflow:** -2^31 / -1 gives LO = 0x80000000, HI = 0, from natural truncation.
- **`busy`:** 1 in CALC and FIX.
- **`stall`:** `busy & (start | rd_hilo)`.
- **`start` while busy:** ignored. The stalled instruction re-presents `start` once the unit returns to IDLE, and is accepted the cycle after `done`.
- **Reset:**
  - `rst_n`=0 at any edge, including mid-operation: state IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `done`=0.
  - The in-flight result is discarded.

## Timing
- Start is sampled at edge E0.
- CALC spans edges E1..E32.
- FIX spans edge E33: HI/LO update and `done`=1 for the cycle following E33.
- Latency from the start cycle to HI/LO valid is 34 cycles; the same for all ops and operand values.
- `busy` is high from after E0 until E33; `busy`=0 in the `done` cycle.
- An MFHI/MFLO in the `done` cycle reads the new values with no stall.
- `hi`/`lo` are registered and change only at FIX or reset.
- `stall` has no registered delay.

## Structure
- The following go in `macros.v`:
  - `MdOpBus`.
  - Op codes `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - State encoding `MD_IDLE`, `MD_CALC`, `MD_FIX`.
- Single module; no sub-module. The control unit decodes `op` from func and ANDs `~stall` into `write_pc_ir`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001 at cycle 34; `done` high exactly 1 cycle.
- MULT a=-3, b=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7, b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2: LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0: LO=0xFFFFFFFF, HI=0x00001234, still 34 cycles.
- `rd_hilo` held from cycle 5 after start: `stall`=1 until E33, 0 in the `done` cycle. A second `start` at cycle 3 is ignored, then accepted after `done`.
- `rst_n`=0 at cycle 10 of a DIV: next edge `busy`=0, `hi`=`lo`=0, no `done`. A following MULTU 6×7 gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   md_state_e     : sequencer state encoding (IDLE / CALC / FIX)
//   MD_MULT..DIVU  : 2-bit operation codes presented on the op port
//   md_is_signed() : true for MULT and DIV
//   md_is_div()    : true for DIV and DIVU
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Even op codes are the signed variants.
    function automatic logic md_is_signed(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

    // Upper op bit selects the divide family.
    function automatic logic md_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// One operation takes a start edge, WIDTH iteration edges and one sign-fix
// edge; HI/LO are written on the fix edge and done pulses for one cycle.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset (discards any in-flight result)
//   start   : EXE stage holds a mul/div instruction (ignored while busy)
//   op      : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   a, b    : rs / rt operands after forwarding
//   rd_hilo : EXE/ID holds MFHI/MFLO
//   hi, lo  : HI / LO registers
//   busy    : operation in flight (CALC or FIX)
//   done    : one-cycle pulse, HI/LO were updated on the preceding edge
//   stall   : combinational hold request for PC/IR
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int                 CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ALL_ONES_W = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ZERO_2W    = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    md_state_e          state_r;
    md_state_e          state_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               fix_s;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Operation context captured at start.
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opa_r;    // multiplier (shifts right) or dividend (shifts left)
    logic [WIDTH-1:0]   opb_r;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a_r;  // unmodified a, returned in HI on divide by zero
    logic [2*WIDTH-1:0] acc_r;    // product, or {remainder, quotient}
    logic               sign_a_r;
    logic               sign_b_r;
    logic               dbz_r;

    // Operand conditioning.
    logic               in_signed_s;
    logic               sign_a_in_s;
    logic               sign_b_in_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;

    // One iteration step.
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] div_acc_s;
    logic [2*WIDTH-1:0] iter_acc_s;

    // Final sign correction.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // State register plus registered busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= MD_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state logic: start is only honoured from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (start) begin
                    state_nxt_s = MD_CALC;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = MD_FIX;
                end else begin
                    state_nxt_s = MD_CALC;
                end
            end
            MD_FIX: begin
                state_nxt_s = MD_IDLE;
            end
            default: begin
                state_nxt_s = MD_IDLE;
            end
        endcase
    end

    // State-derived outputs; busy is registered from the next state so it
    // drops in the same cycle done rises.
    always_comb begin
        busy_nxt_s = 1'b0;
        fix_s      = 1'b0;
        case (state_nxt_s)
            MD_CALC: busy_nxt_s = 1'b1;
            MD_FIX:  busy_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
        if (state_r == MD_FIX) begin
            fix_s = 1'b1;
        end else begin
            fix_s = 1'b0;
        end
    end

    // Magnitudes and sign flags of the incoming operands.
    always_comb begin
        in_signed_s = md_is_signed(op);
        sign_a_in_s = in_signed_s & a[WIDTH-1];
        sign_b_in_s = in_signed_s & b[WIDTH-1];
        if (sign_a_in_s) begin
            mag_a_s = ~a + ONE_W;
        end else begin
            mag_a_s = a;
        end
        if (sign_b_in_s) begin
            mag_b_s = ~b + ONE_W;
        end else begin
            mag_b_s = b;
        end
    end

    // One shift/add (multiply) or restoring shift/subtract (divide) step.
    always_comb begin
        // Multiply: conditional add into the upper half, then shift {carry, acc} right.
        if (opa_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // Divide: next dividend bit enters the remainder; a clear borrow
        // bit means the trial subtraction is kept and the quotient bit is 1.
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], opa_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (!div_diff_s[WIDTH]) begin
            div_acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        if (md_is_div(op_r)) begin
            iter_acc_s = div_acc_s;
        end else begin
            iter_acc_s = mul_acc_s;
        end
    end

    // Sign correction and divide-by-zero override for the write-back.
    always_comb begin
        quot_s   = acc_r[WIDTH-1:0];
        rem_s    = acc_r[2*WIDTH-1:WIDTH];
        prod_s   = acc_r;
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        if (md_is_div(op_r)) begin
            if (dbz_r) begin
                res_hi_s = raw_a_r;
                res_lo_s = ALL_ONES_W;
            end else begin
                // Sign flags are only ever set for the signed ops.
                if (sign_a_r ^ sign_b_r) begin
                    res_lo_s = ~quot_s + ONE_W;
                end else begin
                    res_lo_s = quot_s;
                end
                if (sign_a_r) begin
                    res_hi_s = ~rem_s + ONE_W;
                end else begin
                    res_hi_s = rem_s;
                end
            end
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                prod_s = ~acc_r + ONE_2W;
            end else begin
                prod_s = acc_r;
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Datapath: operand capture, iteration, HI/LO commit and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            op_r     <= MD_MULT;
            opa_r    <= ZERO_W;
            opb_r    <= ZERO_W;
            raw_a_r  <= ZERO_W;
            acc_r    <= ZERO_2W;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            done_r   <= 1'b0;
        end else begin
            done_r <= fix_s;
            case (state_r)
                MD_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        opa_r    <= mag_a_s;
                        opb_r    <= mag_b_s;
                        raw_a_r  <= a;
                        sign_a_r <= sign_a_in_s;
                        sign_b_r <= sign_b_in_s;
                        dbz_r    <= (b == ZERO_W);
                        acc_r    <= ZERO_2W;
                        cnt_r    <= CNT_ZERO;
                    end
                end
                MD_CALC: begin
                    acc_r <= iter_acc_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (md_is_div(op_r)) begin
                        opa_r <= {opa_r[WIDTH-2:0], 1'b0};
                    end else begin
                        opa_r <= {1'b0, opa_r[WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    hi_r <= res_hi_s;
                    lo_r <= res_lo_s;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign stall = busy_r & (start | rd_hilo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes the expected
// {HI,LO} and the start cycle for every accepted operation; a negedge monitor
// pops on done and checks value, latency, pulse width and HI/LO hold.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        rd_hilo = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    typedef struct {
        logic [63:0] hl;
        int          s;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall(stall)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference results straight from the MIPS arithmetic definitions.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        res = 64'd0;
        case (o)
            2'd0: res = sx * sy;
            2'd1: res = ux * uy;
            2'd2: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Monitor: result check on done, hold check otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            model_hi  <= 32'd0;
            model_lo  <= 32'd0;
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
                chk("busy_low_in_done", {63'd0, busy}, 64'd0);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("hilo_result", {hi, lo}, e.hl);
                    chk("latency", 64'(cyc - e.s), 64'd34);
                    model_hi <= e.hl[63:32];
                    model_lo <= e.hl[31:0];
                end
            end else begin
                chk("hilo_hold", {hi, lo}, {model_hi, model_lo});
            end
            prev_done <= done;
        end
    end

    // Leaves the driver at a negedge with the unit not busy.
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected idle", n);
        end
    endtask

    task automatic issue(input logic [1:0] i_op, input logic [31:0] i_a,
                         input logic [31:0] i_b, input logic [63:0] want);
        wait_idle();
        op    = i_op;
        a     = i_a;
        b     = i_b;
        start = 1'b1;
        sb_q.push_back('{want, cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;

        // Directed values with hand-derived results.
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        issue(2'd0, 32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        issue(2'd2, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(2'd3, 32'd7,         32'd2,         {32'd1, 32'd3});
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        issue(2'd3, 32'h0000_1234, 32'd0,         {32'h0000_1234, 32'hFFFF_FFFF});
        issue(2'd2, 32'hFFFF_FFF0, 32'd0,         {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});

        // Stall behaviour, ignored start while busy, acceptance after done.
        wait_idle();
        op = 2'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        sb_q.push_back('{64'd15, cyc});
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k <= 33) begin
                chk("stall_while_busy", {63'd0, stall}, {63'd0, (start | rd_hilo)});
            end else begin
                chk("stall_in_done", {63'd0, stall}, 64'd0);
                chk("done_after_34", {63'd0, done}, 64'd1);
                sb_q.push_back('{{32'd2, 32'd14}, cyc});
            end
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
            end
            if (k == 5) rd_hilo = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        rd_hilo = 1'b0;

        // Reset in the middle of a divide discards it.
        wait_idle();
        op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_reset_busy", {63'd0, busy}, 64'd0);
        chk("midop_reset_hilo", {hi, lo}, 64'd0);
        chk("midop_reset_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'd1, 32'd6, 32'd7, 64'd42);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            issue(r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
